// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - multi-byte 8N1/8N2 UART word transmitter
// One handshake latches a whole word; bytes go out back-to-back, order chosen by BYTE_ORDER.
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD_BYTES   = 4,
  parameter int BYTE_ORDER   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    send_start,
  input  logic [8*WORD_BYTES-1:0] data_in,
  output logic                    tx,
  output logic                    busy,
  output logic                    data_end
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(WORD_BYTES - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_word_tx: CLKS_PER_BIT must be >= 2");
    end
    if (WORD_BYTES < 1) begin : g_bad_wb
      $error("uart_word_tx: WORD_BYTES must be >= 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_sb
      $error("uart_word_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [BW-1:0] r_byte_idx;
  logic [W-1:0]  r_buf;
  logic          r_tx;

  state_t        w_state;
  logic [CW-1:0] w_cnt;
  logic [2:0]    w_bit_idx;
  logic [BW-1:0] w_byte_idx;
  logic [W-1:0]  w_buf;
  logic          w_tx;
  logic [7:0]    w_cur_byte;
  logic [W-1:0]  w_buf_next_byte;
  logic [2:0]    w_bit_inc;

  // The outgoing byte always sits at the same end of the buffer; the buffer shifts between bytes.
  assign w_cur_byte      = (BYTE_ORDER == 0) ? r_buf[7:0] : r_buf[W-1 -: 8];
  assign w_buf_next_byte = (BYTE_ORDER == 0) ? (r_buf >> 8) : (r_buf << 8);
  assign w_bit_inc       = r_bit_idx + 3'd1;

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_bit_idx  = r_bit_idx;
    w_byte_idx = r_byte_idx;
    w_buf      = r_buf;
    w_tx       = r_tx;
    case (r_state)
      S_IDLE: begin
        w_tx = 1'b1;
        if (send_start) begin
          w_state    = S_START;
          w_cnt      = BIT_LAST;
          w_byte_idx = '0;
          w_buf      = data_in;
          w_tx       = 1'b0;
        end
      end
      S_START: begin
        if (r_cnt == '0) begin
          w_state   = S_DATA;
          w_cnt     = BIT_LAST;
          w_bit_idx = 3'd0;
          w_tx      = w_cur_byte[0];
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          if (r_bit_idx == 3'd7) begin
            w_state = S_STOP;
            w_cnt   = STOP_LAST;
            w_tx    = 1'b1;
          end else begin
            w_cnt     = BIT_LAST;
            w_bit_idx = w_bit_inc;
            w_tx      = w_cur_byte[w_bit_inc];
          end
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == '0) begin
          if (r_byte_idx != BYTE_LAST) begin
            w_state    = S_START;
            w_cnt      = BIT_LAST;
            w_byte_idx = r_byte_idx + BW'(1);
            w_buf      = w_buf_next_byte;
            w_tx       = 1'b0;
          end else begin
            w_state = S_DONE;
            w_tx    = 1'b1;
          end
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_tx    = 1'b1;
      end
      default: begin
        w_state = S_IDLE;
        w_tx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_buf      <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_bit_idx  <= w_bit_idx;
      r_byte_idx <= w_byte_idx;
      r_buf      <= w_buf;
      r_tx       <= w_tx;
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
  assign data_end = (r_state == S_DONE);

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - directed bench for uart_word_tx
// Three instances: little-endian word, big-endian word, single byte with two stop bits.
module tb_uart_word_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        st_le, st_be, st_sb;
  logic [31:0] d_le, d_be;
  logic [7:0]  d_sb;
  logic        tx_le, tx_be, tx_sb;
  logic        bz_le, bz_be, bz_sb;
  logic        de_le, de_be, de_sb;

  int n_asserts = 0;
  int n_fails   = 0;

  logic cap_tx [0:255];
  logic cap_bz [0:255];
  logic cap_de [0:255];

  uart_word_tx #(.CLKS_PER_BIT(4), .WORD_BYTES(4), .BYTE_ORDER(0), .STOP_BITS(1)) u_le (
    .clk(clk), .reset(reset), .send_start(st_le), .data_in(d_le),
    .tx(tx_le), .busy(bz_le), .data_end(de_le)
  );

  uart_word_tx #(.CLKS_PER_BIT(4), .WORD_BYTES(4), .BYTE_ORDER(1), .STOP_BITS(1)) u_be (
    .clk(clk), .reset(reset), .send_start(st_be), .data_in(d_be),
    .tx(tx_be), .busy(bz_be), .data_end(de_be)
  );

  uart_word_tx #(.CLKS_PER_BIT(3), .WORD_BYTES(1), .BYTE_ORDER(0), .STOP_BITS(2)) u_sb (
    .clk(clk), .reset(reset), .send_start(st_sb), .data_in(d_sb),
    .tx(tx_sb), .busy(bz_sb), .data_end(de_sb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] outs(input int sel);
    case (sel)
      0:       outs = {tx_le, bz_le, de_le};
      1:       outs = {tx_be, bz_be, de_be};
      default: outs = {tx_sb, bz_sb, de_sb};
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v, input logic [31:0] data);
    case (sel)
      0:       begin st_le = v; d_le = data; end
      1:       begin st_be = v; d_be = data; end
      default: begin st_sb = v; d_sb = data[7:0]; end
    endcase
  endtask

  // Called at a negedge; exp holds the bytes in transmit order, first byte in [7:0].
  task automatic run_word(input int sel, input logic [31:0] word, input logic [31:0] exp,
                          input bit hold, input string tag);
    int cpb, nb, sb, fl, n, errs, pulses, busy_err, r, sym;
    logic [31:0] got, mask;
    logic [2:0]  o;
    logic        e;
    if (sel == 2) begin cpb = 3; nb = 1; sb = 2; end
    else          begin cpb = 4; nb = 4; sb = 1; end
    fl = (9 + sb) * cpb;
    n  = nb * fl;
    set_start(sel, 1'b1, word);
    @(negedge clk);
    if (!hold) set_start(sel, 1'b0, ~word);
    for (int t = 0; t <= n + 1; t++) begin
      if (t > 0) @(negedge clk);
      o = outs(sel);
      cap_tx[t] = o[2];
      cap_bz[t] = o[1];
      cap_de[t] = o[0];
      if (hold && t == n / 2) set_start(sel, 1'b1, 32'hDEADBEEF);
    end
    errs = 0; pulses = 0; busy_err = 0; got = '0;
    for (int t = 0; t <= n + 1; t++) begin
      if (t < n) begin
        r   = t % fl;
        sym = r / cpb;
        if (sym == 0)      e = 1'b0;
        else if (sym <= 8) e = exp[8 * (t / fl) + sym - 1];
        else               e = 1'b1;
      end else begin
        e = 1'b1;
      end
      if (cap_tx[t] !== e) errs++;
      if (cap_de[t] === 1'b1) pulses++;
      if (cap_bz[t] !== (t < n)) busy_err++;
    end
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < 8; k++)
        got[8 * b + k] = cap_tx[b * fl + (1 + k) * cpb + cpb / 2];
    mask = (nb == 4) ? 32'hFFFFFFFF : 32'h000000FF;
    chk({tag, " tx_low_first"}, {31'd0, cap_tx[0]}, 32'd0);
    chk({tag, " waveform"}, errs, 32'd0);
    chk({tag, " bytes"}, got, exp & mask);
    chk({tag, " end_at_n"}, {31'd0, cap_de[n]}, 32'd1);
    chk({tag, " end_pulses"}, pulses, 32'd1);
    chk({tag, " busy"}, busy_err, 32'd0);
  endtask

  initial begin
    int bad;
    logic [10:0] pat;
    reset = 1'b1;
    st_le = 1'b0; st_be = 1'b0; st_sb = 1'b0;
    d_le = '0; d_be = '0; d_sb = '0;
    repeat (3) @(negedge clk);
    chk("reset_le", {29'd0, tx_le, bz_le, de_le}, 32'b100);
    chk("reset_be", {29'd0, tx_be, bz_be, de_be}, 32'b100);
    chk("reset_sb", {29'd0, tx_sb, bz_sb, de_sb}, 32'b100);
    reset = 1'b0;
    @(negedge clk);

    run_word(0, 32'h12345678, 32'h12345678, 1'b0, "le");
    @(negedge clk);

    run_word(0, 32'h000000FF, 32'h000000FF, 1'b1, "hold");
    @(negedge clk);
    chk("hold_restart", {30'd0, tx_le, bz_le}, 32'b01);
    set_start(0, 1'b0, 32'h0);

    // Land in the DATA phase of byte 2 of the restarted word, then abort it.
    repeat (90) @(negedge clk);
    chk("mid_word_busy", {31'd0, bz_le}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort", {29'd0, tx_le, bz_le, de_le}, 32'b100);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ({tx_le, bz_le, de_le} !== 3'b100) bad++;
    end
    chk("abort_quiet", bad, 32'd0);
    run_word(0, 32'h11223344, 32'h11223344, 1'b0, "after_reset");

    @(negedge clk);
    run_word(1, 32'hA5C30F81, 32'h810FC3A5, 1'b0, "be");
    run_word(1, 32'h01020304, 32'h04030201, 1'b0, "b2b_1");
    run_word(1, 32'hFFEE0055, 32'h5500EEFF, 1'b0, "b2b_2");

    @(negedge clk);
    run_word(2, 32'h0000003C, 32'h0000003C, 1'b0, "sb2");
    for (int s = 0; s < 11; s++) pat[s] = cap_tx[3 * s + 1];
    chk("sb2_pattern", {21'd0, pat}, 32'h678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
